pio_pinpos_out_fifo: RTL and testbench

Avalon-MM output PIO that carries 8-bit pin-position values from the HPS into the FPGA string-art datapath. It is the write-direction counterpart of the 8-bit pin-position input PIOs. Software writes positions into a 4-entry FIFO. The block presents them on a valid/ready stream to the fabric consumer, and exposes status, overflow and handshake counters for readback.

---
 rtl/pio_pinpos_pkg.sv | 22 ++
 rtl/pio_sync_fifo.sv | 63 ++++++
 rtl/pio_pinpos_out_fifo.sv | 107 ++++++++++
 tb/tb_pio_pinpos_out_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pinpos_pkg.sv
// Shared constants for the pin-position output PIO: register map, STATUS layout
// and default geometry.
package pio_pinpos_pkg;

  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_OVF    = 2'd2;
  localparam logic [1:0] ADDR_XFERS  = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 2;

  // Width of an occupancy count that can represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pio_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; head reads as zero when
// empty so the consumer never sees stale storage.
module pio_sync_fifo
  import pio_pinpos_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pio_pinpos_out_fifo.sv
// Avalon-MM output PIO: HPS writes pin positions into a FIFO that is drained by
// a valid/ready consumer; status, overflow and handshake counters are readable.
module pio_pinpos_out_fifo
  import pio_pinpos_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  // Handshake: an entry transfers on a rising clk edge where out_valid and
  // out_ready are both high; out_port/out_valid hold until that happens.
  input  logic              out_ready
);

  logic              wr_data, wr_status, wr_ovf, wr_xfers;
  logic              flush, handshake, xfer_inc, push_drop;
  logic [DATA_W-1:0] head;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic [7:0]        ovf_q, ovf_d;
  logic [15:0]       xfers_q, xfers_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       status_word;

  assign wr_data   = ~write_n & (address == ADDR_DATA);
  assign wr_status = ~write_n & (address == ADDR_STATUS);
  assign wr_ovf    = ~write_n & (address == ADDR_OVF);
  assign wr_xfers  = ~write_n & (address == ADDR_XFERS);

  assign flush     = wr_status & writedata[0];
  assign handshake = out_valid & out_ready;
  assign xfer_inc  = handshake & ~flush;
  // Pushes lost to a flush are discarded silently, not treated as overflow.
  assign push_drop = wr_data & ~flush & full & ~handshake;

  pio_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (wr_data),
    .pop_i   (handshake),
    .flush_i (flush),
    .wdata_i (writedata[DATA_W-1:0]),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign out_port  = head;
  assign out_valid = ~empty;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_ovf) ovf_d = '0;
    else if (push_drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_comb begin
    xfers_d = xfers_q;
    if (wr_xfers) xfers_d = '0;
    else if (xfer_inc) xfers_d = xfers_q + 16'd1;
  end

  always_comb begin
    status_word                    = '0;
    status_word[ST_EMPTY]          = empty;
    status_word[ST_FULL]           = full;
    status_word[ST_COUNT_LSB +: CW] = count;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d = 32'(head);
      ADDR_STATUS: readdata_d = status_word;
      ADDR_OVF:    readdata_d = 32'(ovf_q);
      ADDR_XFERS:  readdata_d = 32'(xfers_q);
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q      <= '0;
      xfers_q    <= '0;
      readdata_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      xfers_q    <= xfers_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_pio_pinpos_out_fifo.sv
// Bench for pio_pinpos_out_fifo: directed register vectors plus a queue model of
// the stream side checked on every falling edge.
module tb_pio_pinpos_out_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  pio_pinpos_out_fifo dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q[$];
  logic       m_flush, m_push, m_hs;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs are set just after a rising edge and held through the next.
  task automatic step(input logic wr, input logic [1:0] a, input logic [31:0] d,
                      input logic rdy, input logic chk, input logic [31:0] exp,
                      input string name);
    write_n   = ~wr;
    address   = a;
    writedata = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
    if (chk) check(name, readdata, exp);
  endtask

  task automatic add(input logic wr, input logic [1:0] a, input logic [31:0] d,
                     input logic rdy, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.rdy = rdy; v.chk = chk; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Stream scoreboard: expected head compared every cycle, popped on handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_port", 32'(out_port), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      m_flush = !write_n && address == 2'd1 && writedata[0];
      m_push  = !write_n && address == 2'd0 && !m_flush;
      m_hs    = (exp_q.size() != 0) && out_ready;
      if (m_flush) begin
        exp_q.delete();
      end else begin
        if (m_hs) void'(exp_q.pop_front());
        if (m_push && exp_q.size() < DEPTH) exp_q.push_back(writedata[7:0]);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    write_n   = 1'b1;
    address   = 2'd0;
    writedata = '0;
    out_ready = 1'b0;

    // Reset readback, fill with overflow, drain, push-during-pop, flush.
    add(0, 0, 0, 0, 1, 32'h0);
    add(0, 1, 0, 0, 1, 32'h1);
    add(0, 2, 0, 0, 1, 32'h0);
    add(0, 3, 0, 0, 1, 32'h0);
    add(1, 0, 32'h11, 0, 0, 0);
    add(1, 0, 32'h22, 0, 0, 0);
    add(1, 0, 32'h33, 0, 0, 0);
    add(1, 0, 32'h44, 0, 0, 0);
    add(1, 0, 32'h55, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h12);
    add(0, 2, 0, 0, 1, 32'h1);
    add(0, 0, 0, 0, 1, 32'h11);
    add(0, 0, 0, 1, 1, 32'h11);
    add(0, 0, 0, 1, 1, 32'h22);
    add(0, 0, 0, 1, 1, 32'h33);
    add(0, 0, 0, 1, 1, 32'h44);
    add(0, 3, 0, 0, 1, 32'h4);
    add(0, 1, 0, 0, 1, 32'h1);
    add(1, 0, 32'hA1, 0, 0, 0);
    add(1, 0, 32'hA2, 0, 0, 0);
    add(1, 0, 32'hA3, 0, 0, 0);
    add(1, 0, 32'hA4, 0, 0, 0);
    add(1, 0, 32'h66, 1, 0, 0);
    add(0, 2, 0, 0, 1, 32'h1);
    add(0, 1, 0, 0, 1, 32'h12);
    add(0, 0, 0, 1, 1, 32'hA2);
    add(0, 0, 0, 1, 1, 32'hA3);
    add(0, 0, 0, 1, 1, 32'hA4);
    add(0, 0, 0, 1, 1, 32'h66);
    add(0, 3, 0, 0, 1, 32'h9);
    add(0, 1, 0, 0, 1, 32'h1);
    add(1, 0, 32'hB1, 0, 0, 0);
    add(1, 0, 32'hB2, 0, 0, 0);
    add(1, 0, 32'hB3, 0, 0, 0);
    add(1, 1, 32'h1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 32'h1);
    add(0, 3, 0, 0, 1, 32'h9);

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].rdy, tbl[i].chk, tbl[i].exp,
           $sformatf("vec%0d", i));
    end

    // XFERS wrap: one entry resident, then 65535 push+pop cycles, then one pop.
    step(1, 3, 0, 0, 0, 0, "");
    step(1, 0, 32'($urandom_range(0, 255)), 0, 0, 0, "");
    for (int i = 0; i < 65535; i++) begin
      step(1, 0, 32'($urandom_range(0, 255)), 1, 0, 0, "");
    end
    step(0, 3, 0, 0, 1, 32'hFFFF, "xfers_ffff");
    step(0, 3, 0, 1, 0, 0, "");
    step(0, 3, 0, 0, 1, 32'h0, "xfers_wrap");
    step(0, 1, 0, 0, 1, 32'h1, "status_after_wrap");

    // Overflow saturation and clear.
    step(1, 2, 0, 0, 0, 0, "");
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 32'($urandom_range(0, 255)), 0, 0, 0, "");
    end
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 32'($urandom_range(0, 255)), 0, 0, 0, "");
    end
    step(0, 2, 0, 0, 1, 32'd255, "ovf_sat");
    step(1, 2, 32'hDEAD, 0, 0, 0, "");
    step(0, 2, 0, 0, 1, 32'h0, "ovf_clear");
    step(0, 1, 0, 0, 1, 32'h12, "status_full");

    // Reset while full: everything queued is lost immediately.
    reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_port", 32'(out_port), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(0, 1, 0, 1, 1, 32'h1, "status_after_rst");
    step(0, 3, 0, 0, 1, 32'h0, "xfers_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
